cw_gap_extract: RTL and testbench

- Consumer stage directly downstream of best_d in the constant-weight encoder.
- Each step it drives the residual (n, t) into best_d and takes back d and u_minus_1.
- It pulls message bits serially and, per Sendrier-style decoding, either skips d positions (flag bit 1) or reads a truncated-binary gap delta < d (flag bit 0).
- It emits one gap per set position until t reaches 0.

---
 rtl/cw_gap_extract.sv | 229 ++++++++++++++++++++++
 tb/tb_cw_gap_extract.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw_gap_extract.sv
// Constant-weight decoder back end: drives (n, t) into best_d and turns serial message bits into gaps.
// Optional macro CW_ABS_POS_EN adds pos_abs, the absolute index of each emitted set position.
`timescale 1ns/1ps
module cw_gap_extract #(
  parameter int N_W    = 12,
  parameter int T_W    = 5,
  parameter int D_W    = 11,
  parameter int BD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n_init,
  input  logic [T_W-1:0] t_init,
  output logic [N_W-1:0] n_cur,
  output logic [T_W-1:0] t_cur,
  input  logic [D_W-1:0] d,
  input  logic [3:0]     u_minus_1,
  input  logic           bit_in,
  input  logic           bit_valid,
  output logic           bit_ready,
  output logic [D_W-1:0] gap,
  output logic           gap_valid,
  input  logic           gap_ready,
  output logic           busy,
`ifdef CW_ABS_POS_EN
  output logic [N_W-1:0] pos_abs,
`endif
  output logic           done
);

  localparam int WC_W = (BD_LAT < 1) ? 1 : $clog2(BD_LAT + 1);
  localparam logic [WC_W-1:0] BD_LAT_C = WC_W'(BD_LAT);
  localparam logic [N_W-1:0]  ONE_N    = N_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_D,
    S_READ_FLAG,
    S_READ_BITS,
    S_CHECK,
    S_READ_EXTRA,
    S_EMIT,
    S_FILL,
    S_DONE
  } state_t;

  state_t          state_r;
  logic [D_W-1:0]  d_r;
  logic [4:0]      u_r;
  logic [N_W-1:0]  thr_r;
  logic [N_W-1:0]  acc_r;
  logic [3:0]      cnt_r;
  logic [WC_W-1:0] wait_cnt_r;
  logic            fill_r;

  logic [N_W-1:0]  d_ext;
  logic [N_W-1:0]  d_r_ext;
  logic [N_W-1:0]  gap_ext;
  logic [N_W-1:0]  t_ext;
  logic [4:0]      u_next;
  logic [N_W-1:0]  thr_next;
  logic [N_W-1:0]  flag_n_next;
  logic [N_W-1:0]  emit_n_next;
  logic [D_W-1:0]  extra_gap;
  logic            bit_hs;

  assign d_ext       = {{(N_W-D_W){1'b0}}, d};
  assign d_r_ext     = {{(N_W-D_W){1'b0}}, d_r};
  assign gap_ext     = {{(N_W-D_W){1'b0}}, gap};
  assign t_ext       = {{(N_W-T_W){1'b0}}, t_cur};
  assign u_next      = {1'b0, u_minus_1} + 5'd1;
  // 2^u wraps to 0 past N_W bits, which is harmless since d never gets that large.
  assign thr_next    = (ONE_N << u_next) - d_ext;
  assign flag_n_next = n_cur - d_r_ext;
  assign emit_n_next = n_cur - gap_ext - ONE_N;
  assign extra_gap   = {acc_r[D_W-2:0], bit_in} - thr_r[D_W-1:0];
  assign bit_hs      = bit_valid && bit_ready;

  assign bit_ready = (state_r == S_READ_FLAG) || (state_r == S_READ_BITS) ||
                     (state_r == S_READ_EXTRA);
  assign busy      = (state_r != S_IDLE) && (state_r != S_DONE);
  assign done      = (state_r == S_DONE);

`ifdef CW_ABS_POS_EN
  logic [N_W-1:0] base_r;
  assign pos_abs = base_r + gap_ext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      n_cur      <= '0;
      t_cur      <= '0;
      gap        <= '0;
      gap_valid  <= 1'b0;
      d_r        <= '0;
      u_r        <= '0;
      thr_r      <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      wait_cnt_r <= '0;
      fill_r     <= 1'b0;
`ifdef CW_ABS_POS_EN
      base_r     <= '0;
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_cur      <= n_init;
            t_cur      <= t_init;
            wait_cnt_r <= '0;
            fill_r     <= 1'b0;
`ifdef CW_ABS_POS_EN
            base_r     <= '0;
`endif
            state_r    <= (t_init == '0) ? S_DONE : S_WAIT_D;
          end
        end

        S_WAIT_D: begin
          // best_d answers BD_LAT edges after n_cur/t_cur settle.
          if (wait_cnt_r == BD_LAT_C) begin
            wait_cnt_r <= '0;
            d_r        <= d;
            u_r        <= u_next;
            thr_r      <= thr_next;
            state_r    <= (t_ext == n_cur) ? S_FILL : S_READ_FLAG;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
        end

        S_READ_FLAG: begin
          if (bit_hs) begin
            if (bit_in) begin
              if (d_r_ext > n_cur) begin
                state_r <= S_DONE;
              end else begin
                n_cur   <= flag_n_next;
`ifdef CW_ABS_POS_EN
                base_r  <= base_r + d_r_ext;
`endif
                state_r <= S_WAIT_D;
              end
            end else if (d_r == D_W'(1)) begin
              gap       <= '0;
              gap_valid <= 1'b1;
              state_r   <= S_EMIT;
            end else if (u_r == 5'd1) begin
              acc_r   <= '0;
              state_r <= S_CHECK;
            end else begin
              acc_r   <= '0;
              cnt_r   <= 4'(u_r - 5'd1);
              state_r <= S_READ_BITS;
            end
          end
        end

        S_READ_BITS: begin
          if (bit_hs) begin
            acc_r <= {acc_r[N_W-2:0], bit_in};
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
              state_r <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          // Short codewords (u-1 bits) cover values below thr; the rest need one more bit.
          if (acc_r < thr_r) begin
            gap       <= acc_r[D_W-1:0];
            gap_valid <= 1'b1;
            state_r   <= S_EMIT;
          end else begin
            state_r <= S_READ_EXTRA;
          end
        end

        S_READ_EXTRA: begin
          if (bit_hs) begin
            gap       <= extra_gap;
            gap_valid <= 1'b1;
            state_r   <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (gap_ready) begin
            if (gap_ext >= n_cur) begin
              gap_valid <= 1'b0;
              state_r   <= S_DONE;
            end else begin
              n_cur  <= emit_n_next;
              t_cur  <= t_cur - 1'b1;
`ifdef CW_ABS_POS_EN
              base_r <= base_r + gap_ext + ONE_N;
`endif
              if (t_cur == T_W'(1)) begin
                gap_valid <= 1'b0;
                state_r   <= S_DONE;
              end else if (fill_r) begin
                // Fill mode keeps gap=0 valid back to back until t runs out.
                gap       <= '0;
                gap_valid <= 1'b1;
              end else begin
                gap_valid <= 1'b0;
                state_r   <= S_WAIT_D;
              end
            end
          end
        end

        S_FILL: begin
          fill_r    <= 1'b1;
          gap       <= '0;
          gap_valid <= 1'b1;
          state_r   <= S_EMIT;
        end

        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_gap_extract.sv
// Directed bench for cw_gap_extract with a registered best_d stand-in keyed on (n_cur, t_cur).
`timescale 1ns/1ps
module tb_cw_gap_extract;
  localparam int N_W = 12;
  localparam int T_W = 5;
  localparam int D_W = 11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N_W-1:0] n_init = '0;
  logic [T_W-1:0] t_init = '0;
  logic [N_W-1:0] n_cur;
  logic [T_W-1:0] t_cur;
  logic [D_W-1:0] d = '0;
  logic [3:0]     u_minus_1 = '0;
  logic           bit_in = 1'b0;
  logic           bit_valid = 1'b0;
  logic           bit_ready;
  logic [D_W-1:0] gap;
  logic           gap_valid;
  logic           gap_ready = 1'b0;
  logic           busy;
  logic           done;
`ifdef CW_ABS_POS_EN
  logic [N_W-1:0] pos_abs;
`endif

  int n_asserts = 0;
  int n_fail = 0;
  bit tmo;

  // best_d stand-in: answers (bd_d, bd_u) only for the keyed (n, t), otherwise d=1,u-1=0.
  logic [N_W-1:0] bd_n = '0;
  logic [T_W-1:0] bd_t = '0;
  logic [D_W-1:0] bd_d = '0;
  logic [3:0]     bd_u = '0;

  cw_gap_extract dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_init(n_init), .t_init(t_init),
    .n_cur(n_cur), .t_cur(t_cur), .d(d), .u_minus_1(u_minus_1),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .gap(gap), .gap_valid(gap_valid), .gap_ready(gap_ready), .busy(busy),
`ifdef CW_ABS_POS_EN
    .pos_abs(pos_abs),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (n_cur == bd_n && t_cur == bd_t) begin
      d <= bd_d;
      u_minus_1 <= bd_u;
    end else begin
      d <= D_W'(1);
      u_minus_1 <= 4'd0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_bd(input logic [N_W-1:0] n, input logic [T_W-1:0] t,
                        input logic [D_W-1:0] dv, input logic [3:0] uv);
    bd_n = n; bd_t = t; bd_d = dv; bd_u = uv;
  endtask

  task automatic do_start(input logic [N_W-1:0] n, input logic [T_W-1:0] t);
    @(negedge clk);
    n_init = n; t_init = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one bit (called at a negedge) and returns at the negedge after it is consumed.
  task automatic send_bit(input logic b);
    int k;
    bit_in = b; bit_valid = 1'b1; k = 0;
    while (!bit_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bit_ready) tmo = 1'b1;
    else @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic take_gap(output logic [D_W-1:0] g);
    int k;
    gap_ready = 1'b1; k = 0;
    while (!gap_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!gap_valid) begin
      tmo = 1'b1;
      g = '1;
    end else begin
      g = gap;
      @(negedge clk);
    end
    gap_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_asserts++;
    if ({n_cur, t_cur, gap, gap_valid, bit_ready, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: n=%0d t=%0d gap=%0d gv=%b br=%b busy=%b done=%b, required all 0",
               n_cur, t_cur, gap, gap_valid, bit_ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic [D_W-1:0] g;
    tmo = 0;
    set_bd(12'd16, 5'd2, 11'd4, 4'd1);
    do_start(12'd16, 5'd2);
    n_asserts++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
    send_bit(0); send_bit(1); send_bit(0);
    set_bd(12'd13, 5'd1, 11'd5, 4'd2);
    take_gap(g);
    n_asserts++;
    if (g !== 11'd2) begin n_fail++; $display("FAIL basic_gap1: got %0d required 2", g); end
    n_asserts++;
    if (n_cur !== 12'd13 || t_cur !== 5'd1) begin
      n_fail++; $display("FAIL basic_nt1: got n=%0d t=%0d required n=13 t=1", n_cur, t_cur);
    end
    send_bit(0); send_bit(1); send_bit(0);
    take_gap(g);
    n_asserts++;
    if (g !== 11'd2) begin n_fail++; $display("FAIL short_code_gap: got %0d required 2", g); end
    n_asserts++;
    if (n_cur !== 12'd10 || t_cur !== 5'd0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got n=%0d t=%0d done=%b busy=%b required n=10 t=0 done=1 busy=0",
               n_cur, t_cur, done, busy);
    end
    n_asserts++;
    if (tmo) begin n_fail++; $display("FAIL basic_timeout: handshake timed out, required none"); end
    $display("test_basic: gaps 2,2 n=%0d t=%0d", n_cur, t_cur);
  endtask

  task automatic test_extra_read();
    logic [D_W-1:0] g;
    tmo = 0;
    set_bd(12'd16, 5'd1, 11'd5, 4'd2);
    do_start(12'd16, 5'd1);
    send_bit(0); send_bit(1); send_bit(1); send_bit(1);
    take_gap(g);
    n_asserts++;
    if (g !== 11'd4) begin n_fail++; $display("FAIL extra_gap4: got %0d required 4", g); end
    n_asserts++;
    if (n_cur !== 12'd11 || done !== 1'b1) begin
      n_fail++; $display("FAIL extra_n4: got n=%0d done=%b required n=11 done=1", n_cur, done);
    end
    do_start(12'd16, 5'd1);
    send_bit(0);
    do_start(12'd100, 5'd9);
    n_asserts++;
    if (n_cur !== 12'd16 || t_cur !== 5'd1) begin
      n_fail++; $display("FAIL start_while_busy: got n=%0d t=%0d required n=16 t=1", n_cur, t_cur);
    end
    send_bit(1); send_bit(1); send_bit(0);
    take_gap(g);
    n_asserts++;
    if (g !== 11'd3) begin n_fail++; $display("FAIL extra_gap3: got %0d required 3", g); end
    n_asserts++;
    if (n_cur !== 12'd12 || t_cur !== 5'd0) begin
      n_fail++; $display("FAIL extra_n3: got n=%0d t=%0d required n=12 t=0", n_cur, t_cur);
    end
    n_asserts++;
    if (tmo) begin n_fail++; $display("FAIL extra_timeout: handshake timed out, required none"); end
    $display("test_extra_read: gaps 4,3");
  endtask

  task automatic test_skip();
    logic [D_W-1:0] g;
    logic r1, r2;
    tmo = 0;
    set_bd(12'd2048, 5'd27, 11'd64, 4'd5);
    do_start(12'd2048, 5'd27);
    send_bit(1);
    n_asserts++;
    if (n_cur !== 12'd1984 || t_cur !== 5'd27 || gap_valid !== 1'b0 || bit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_state: got n=%0d t=%0d gv=%b br=%b required n=1984 t=27 gv=0 br=0",
               n_cur, t_cur, gap_valid, bit_ready);
    end
    set_bd(12'd1984, 5'd27, 11'd1, 4'd0);
    @(negedge clk); r1 = bit_ready;
    @(negedge clk); r2 = bit_ready;
    n_asserts++;
    if ({r1, r2} !== 2'b01) begin
      n_fail++; $display("FAIL skip_requery: got ready seq %b%b required 01", r1, r2);
    end
    send_bit(0);
    take_gap(g);
    n_asserts++;
    if (g !== 11'd0 || n_cur !== 12'd1983 || t_cur !== 5'd26) begin
      n_fail++; $display("FAIL skip_d1_gap: got gap=%0d n=%0d t=%0d required 0 1983 26", g, n_cur, t_cur);
    end
    n_asserts++;
    if (tmo) begin n_fail++; $display("FAIL skip_timeout: handshake timed out, required none"); end
    pulse_reset();
    $display("test_skip: n after flag=1984, d=1 gap=0");
  endtask

  task automatic test_fill();
    int cnt;
    bit seen_ready, bad_gap;
    cnt = 0; seen_ready = 0; bad_gap = 0;
    set_bd(12'd3, 5'd3, 11'd1, 4'd0);
    do_start(12'd3, 5'd3);
    bit_valid = 1'b1;
    gap_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bit_ready) seen_ready = 1;
      if (gap_valid) begin
        cnt++;
        if (gap !== 11'd0) bad_gap = 1;
      end
      @(negedge clk);
    end
    gap_ready = 1'b0;
    bit_valid = 1'b0;
    n_asserts++;
    if (cnt != 3) begin n_fail++; $display("FAIL fill_count: got %0d gaps required 3", cnt); end
    n_asserts++;
    if (seen_ready || bad_gap) begin
      n_fail++; $display("FAIL fill_bits: got ready_seen=%b nonzero_gap=%b required 0 0", seen_ready, bad_gap);
    end
    n_asserts++;
    if (done !== 1'b1 || n_cur !== 12'd0 || t_cur !== 5'd0) begin
      n_fail++; $display("FAIL fill_done: got done=%b n=%0d t=%0d required 1 0 0", done, n_cur, t_cur);
    end
    $display("test_fill: %0d zero gaps", cnt);
  endtask

  task automatic test_stall();
    logic [D_W-1:0] g;
    bit bad_stall, bad_hold;
    tmo = 0; bad_stall = 0; bad_hold = 0;
    set_bd(12'd16, 5'd1, 11'd5, 4'd2);
    do_start(12'd16, 5'd1);
    send_bit(0); send_bit(1);
    for (int k = 0; k < 5; k++) begin
      if (bit_ready !== 1'b1 || gap_valid !== 1'b0 || n_cur !== 12'd16) bad_stall = 1;
      @(negedge clk);
    end
    send_bit(1); send_bit(1);
    for (int k = 0; k < 4; k++) begin
      if (gap_valid !== 1'b1 || gap !== 11'd4 || n_cur !== 12'd16) bad_hold = 1;
      @(negedge clk);
    end
    take_gap(g);
    n_asserts++;
    if (bad_stall) begin n_fail++; $display("FAIL stall_bits: state moved while bit_valid low, required stable"); end
    n_asserts++;
    if (bad_hold) begin n_fail++; $display("FAIL stall_gap: gap not held while gap_ready low, required gap=4 valid"); end
    n_asserts++;
    if (g !== 11'd4 || n_cur !== 12'd11) begin
      n_fail++; $display("FAIL stall_result: got gap=%0d n=%0d required 4 11", g, n_cur);
    end
    n_asserts++;
    if (tmo) begin n_fail++; $display("FAIL stall_timeout: handshake timed out, required none"); end
    $display("test_stall: gap=%0d", g);
  endtask

  task automatic test_reset_mid();
    logic [D_W-1:0] g;
    tmo = 0;
    set_bd(12'd16, 5'd1, 11'd5, 4'd2);
    do_start(12'd16, 5'd1);
    send_bit(0); send_bit(1);
    n_asserts++;
    if (bit_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: got br=%b busy=%b required 1 1", bit_ready, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_asserts++;
    if ({n_cur, t_cur, gap, gap_valid, bit_ready, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: n=%0d t=%0d gap=%0d gv=%b br=%b busy=%b done=%b, required all 0",
               n_cur, t_cur, gap, gap_valid, bit_ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start(12'd16, 5'd1);
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    take_gap(g);
    n_asserts++;
    if (g !== 11'd3 || n_cur !== 12'd12) begin
      n_fail++; $display("FAIL rst_rerun: got gap=%0d n=%0d required 3 12", g, n_cur);
    end
    n_asserts++;
    if (tmo) begin n_fail++; $display("FAIL rst_timeout: handshake timed out, required none"); end
    $display("test_reset_mid: rerun gap=%0d", g);
  endtask

`ifdef CW_ABS_POS_EN
  task automatic test_pos_abs();
    logic [D_W-1:0] g;
    int k;
    tmo = 0;
    set_bd(12'd16, 5'd2, 11'd4, 4'd1);
    do_start(12'd16, 5'd2);
    send_bit(1);
    set_bd(12'd12, 5'd2, 11'd4, 4'd1);
    send_bit(0); send_bit(1); send_bit(0);
    k = 0;
    while (!gap_valid && k < 20) begin @(negedge clk); k++; end
    n_asserts++;
    if (gap_valid !== 1'b1 || pos_abs !== 12'd6) begin
      n_fail++; $display("FAIL pos_abs: got gv=%b pos=%0d required 1 6", gap_valid, pos_abs);
    end
    take_gap(g);
    n_asserts++;
    if (tmo || g !== 11'd2) begin n_fail++; $display("FAIL pos_gap: got gap=%0d tmo=%b required 2 0", g, tmo); end
    pulse_reset();
    $display("test_pos_abs: gap=%0d", g);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extra_read();
    test_skip();
    test_fill();
    test_stall();
    test_reset_mid();
`ifdef CW_ABS_POS_EN
    test_pos_abs();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
